truth_table_sweeper: RTL and testbench

Downstream test stage for a 3-input genetic-logic truth-table block such as 0xBC. It drives the block's in1/in2/in3 through all 8 combinations in order and waits a settle interval for each. It then samples the block's out, assembles the observed 8-bit truth table in Cello hex order and compares it against an expected code. Used in simulation benches and on FPGA characterisation rigs to sign off tested circuits.

---
 rtl/truth_table_sweeper_pkg.sv | 19 +
 rtl/truth_table_sweeper_if.sv | 26 ++
 rtl/tt_dwell_timer.sv | 25 ++
 rtl/truth_table_sweeper.sv | 139 +++++++++++++
 tb/tb_truth_table_sweeper.sv | 185 ++++++++++++++++++
 5 files changed

// File: rtl/truth_table_sweeper_pkg.sv
// rtl/truth_table_sweeper_pkg.sv - shared types and helpers for the truth-table sweeper
package cello_tt_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SETTLE,
        SAMPLE,
        DONE
    } state_t;

    localparam int TT_BITS  = 8;
    localparam int N_INPUTS = 3;

    // Cello hex order: combo 000 lands in the MSB, combo 111 in the LSB.
    function automatic logic [2:0] tt_bit_index(input logic [2:0] combo);
        return 3'd7 - combo;
    endfunction

endpackage

// File: rtl/truth_table_sweeper_if.sv
// rtl/truth_table_sweeper_if.sv - control, status and device-under-test signals of the sweeper
interface truth_table_sweeper_if;
    import cello_tt_pkg::*;

    logic               start;
    logic               abort;
    logic               in1;
    logic               in2;
    logic               in3;
    logic               dut_out;
    logic               busy;
    logic               done;
    logic [TT_BITS-1:0] tt_obs;
    logic               unstable;
    logic               pass;

    modport master (
        output start, abort, dut_out,
        input  in1, in2, in3, busy, done, tt_obs, unstable, pass
    );

    modport slave (
        input  start, abort, dut_out,
        output in1, in2, in3, busy, done, tt_obs, unstable, pass
    );
endinterface

// File: rtl/tt_dwell_timer.sv
// rtl/tt_dwell_timer.sv - loadable down-counter with zero flag for settle/sample dwell
module tt_dwell_timer #(
    parameter int WIDTH = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             dec,
    output logic             zero
);
    logic [WIDTH-1:0] count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (dec && count != '0) begin
            count <= count - 1'b1;
        end
    end

    assign zero = (count == '0);
endmodule

// File: rtl/truth_table_sweeper.sv
// rtl/truth_table_sweeper.sv - drives all 8 input combos, samples the output, checks the truth table
module truth_table_sweeper
    import cello_tt_pkg::*;
#(
    parameter int                 SETTLE_CYCLES = 4,
    parameter int                 SAMPLES       = 3,
    parameter logic [TT_BITS-1:0] EXPECTED_TT   = 8'hBC
) (
    input  logic                  clk,
    input  logic                  rst_n,
    truth_table_sweeper_if.slave  bus
);
    localparam int CNT_MAX     = (SETTLE_CYCLES > SAMPLES) ? SETTLE_CYCLES : SAMPLES;
    localparam int CW          = $clog2(CNT_MAX + 1);
    localparam logic [CW-1:0] SETTLE_LOAD = CW'(SETTLE_CYCLES - 1);
    localparam logic [CW-1:0] SAMPLE_LOAD = CW'(SAMPLES - 1);

    state_t             state;
    logic [2:0]         combo;
    logic               ref_val;
    logic               first_sample;
    logic               timer_load;
    logic [CW-1:0]      timer_val;
    logic               timer_dec;
    logic               timer_zero;
    logic [TT_BITS-1:0] tt_next;
    logic               unstable_next;

    tt_dwell_timer #(.WIDTH(CW)) u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (timer_load),
        .load_val (timer_val),
        .dec      (timer_dec),
        .zero     (timer_zero)
    );

    // The sample counter starts at SAMPLES-1, so that value marks the first sample of a combo.
    logic [CW-1:0] sample_left;
    logic          sample_left_zero;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                                       sample_left <= '0;
        else if (timer_load)                              sample_left <= timer_val;
        else if (timer_dec && sample_left != '0)          sample_left <= sample_left - 1'b1;
    end
    assign sample_left_zero = (sample_left == '0);
    assign first_sample     = (sample_left == SAMPLE_LOAD);

    always_comb begin
        timer_load    = 1'b0;
        timer_val     = SETTLE_LOAD;
        timer_dec     = 1'b0;
        tt_next       = bus.tt_obs;
        unstable_next = bus.unstable;
        case (state)
            IDLE: timer_load = bus.start;
            SETTLE: begin
                if (!bus.abort) begin
                    if (timer_zero) begin
                        timer_load = 1'b1;
                        timer_val  = SAMPLE_LOAD;
                    end else begin
                        timer_dec = 1'b1;
                    end
                end
            end
            SAMPLE: begin
                if (!bus.abort) begin
                    if (timer_zero) timer_load = (combo != 3'd7);
                    else            timer_dec  = 1'b1;
                end
                tt_next[tt_bit_index(combo)] = bus.dut_out;
                if (!first_sample && bus.dut_out != ref_val) unstable_next = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state                   <= IDLE;
            combo                   <= 3'd0;
            ref_val                 <= 1'b0;
            {bus.in1, bus.in2, bus.in3} <= 3'b000;
            bus.busy                <= 1'b0;
            bus.done                <= 1'b0;
            bus.tt_obs              <= '0;
            bus.unstable            <= 1'b0;
            bus.pass                <= 1'b0;
        end else begin
            bus.done <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        combo                   <= 3'd0;
                        {bus.in1, bus.in2, bus.in3} <= 3'b000;
                        bus.tt_obs              <= '0;
                        bus.unstable            <= 1'b0;
                        bus.pass                <= 1'b0;
                        bus.busy                <= 1'b1;
                        state                   <= SETTLE;
                    end
                end
                SETTLE, SAMPLE: begin
                    if (bus.abort) begin
                        {bus.in1, bus.in2, bus.in3} <= 3'b000;
                        bus.busy                <= 1'b0;
                        bus.pass                <= 1'b0;
                        state                   <= IDLE;
                    end else if (state == SETTLE) begin
                        if (timer_zero) state <= SAMPLE;
                    end else begin
                        if (first_sample) ref_val <= bus.dut_out;
                        bus.unstable <= unstable_next;
                        if (timer_zero) begin
                            bus.tt_obs <= tt_next;
                            if (combo == 3'd7) begin
                                {bus.in1, bus.in2, bus.in3} <= 3'b000;
                                bus.busy <= 1'b0;
                                bus.done <= 1'b1;
                                bus.pass <= (tt_next == EXPECTED_TT) && !unstable_next;
                                state    <= DONE;
                            end else begin
                                combo                   <= combo + 3'd1;
                                {bus.in1, bus.in2, bus.in3} <= combo + 3'd1;
                                state                   <= SETTLE;
                            end
                        end
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    logic unused_ok;
    assign unused_ok = sample_left_zero;
endmodule

// File: tb/tb_truth_table_sweeper.sv
// tb/tb_truth_table_sweeper.sv - randomized self-checking bench for truth_table_sweeper
module tb_truth_table_sweeper;
    localparam int          S     = 4;
    localparam int          N     = 3;
    localparam logic [7:0]  EXP   = 8'hBC;
    localparam int          PER   = S + N;
    localparam int          SWEEP = 8 * PER;

    logic       clk      = 1'b0;
    logic       rst_n    = 1'b0;
    logic [7:0] model_tt = 8'h00;
    logic       glitch   = 1'b0;
    int         checks   = 0;
    int         failures = 0;

    always #5 clk = ~clk;

    truth_table_sweeper_if bus();

    assign bus.dut_out = model_tt[3'd7 - {bus.in1, bus.in2, bus.in3}] ^ glitch;

    truth_table_sweeper #(
        .SETTLE_CYCLES (S),
        .SAMPLES       (N),
        .EXPECTED_TT   (EXP)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference: every combo yields N samples of the ideal table bit, with one sample optionally flipped.
    function automatic void ref_sweep(input logic [7:0] tt, input int g_edge,
                                      output logic [7:0] tt_o, output logic unst, output logic pss);
        logic v;
        logic first;
        tt_o  = 8'h00;
        unst  = 1'b0;
        first = 1'b0;
        for (int c = 0; c < 8; c++) begin
            for (int j = 0; j < N; j++) begin
                v = tt[7 - c] ^ (g_edge == c * PER + S + 1 + j);
                if (j == 0) first = v;
                else if (v != first) unst = 1'b1;
                if (j == N - 1) tt_o[7 - c] = v;
            end
        end
        pss = (tt_o == EXP) && !unst;
    endfunction

    task automatic sweep(input string tag, input logic [7:0] tt, input int g_edge,
                         input bit restarts, input bit abort_with_start);
        int         done_cnt;
        int         done_at;
        int         seq_err;
        logic [7:0] e_tt;
        logic       e_u;
        logic       e_p;
        logic [2:0] exp_in;
        done_cnt = 0;
        done_at  = -1;
        seq_err  = 0;
        ref_sweep(tt, g_edge, e_tt, e_u, e_p);
        model_tt = tt;
        @(negedge clk);
        bus.start = 1'b1;
        bus.abort = abort_with_start;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        bus.abort = 1'b0;
        check({tag, " busy_after_start"}, bus.busy, 1);
        for (int n = 1; n <= SWEEP + 4; n++) begin
            glitch    = (n == g_edge);
            bus.start = restarts && (n == 10 || n == 30);
            @(posedge clk);
            @(negedge clk);
            exp_in = (n < SWEEP) ? 3'(n / PER) : 3'd0;
            if ({bus.in1, bus.in2, bus.in3} != exp_in) seq_err++;
            if (bus.busy != (n < SWEEP)) seq_err++;
            if (bus.done) begin
                done_cnt++;
                done_at = n;
            end
        end
        glitch    = 1'b0;
        bus.start = 1'b0;
        check({tag, " combo_busy_seq_errors"}, seq_err, 0);
        check({tag, " done_count"}, done_cnt, 1);
        check({tag, " done_edge"}, done_at, SWEEP);
        check({tag, " tt_obs"}, bus.tt_obs, e_tt);
        check({tag, " unstable"}, bus.unstable, e_u);
        check({tag, " pass"}, bus.pass, e_p);
    endtask

    initial begin
        int         done_cnt;
        int         idle_err;
        logic [7:0] rtt;
        int         ge;
        bus.start = 1'b0;
        bus.abort = 1'b0;
        repeat (2) @(negedge clk);
        check("reset_outputs", {bus.busy, bus.done, bus.in1, bus.in2, bus.in3,
                                bus.unstable, bus.pass, bus.tt_obs}, 0);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("idle_no_activity", {bus.busy, bus.done, bus.in1, bus.in2, bus.in3}, 0);

        sweep("bc_nominal", 8'hBC, -1, 1'b0, 1'b0);
        sweep("tied_zero", 8'h00, -1, 1'b0, 1'b0);
        sweep("inverted", 8'h43, -1, 1'b0, 1'b0);
        sweep("glitch_011_s2", 8'hBC, 3 * PER + S + 2, 1'b0, 1'b0);
        check("glitch_bit4", bus.tt_obs[4], 1);
        sweep("restart_ignored", 8'hBC, -1, 1'b1, 1'b0);

        // Abort while combo 100 is being driven.
        model_tt = 8'hBC;
        done_cnt = 0;
        @(negedge clk);
        bus.start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        for (int n = 1; n <= 40; n++) begin
            bus.abort = (n == 4 * PER + 2) || (n == 36) || (n == 37);
            @(posedge clk);
            @(negedge clk);
            if (bus.done) done_cnt++;
            if (n == 4 * PER + 2) begin
                check("abort_busy", bus.busy, 0);
                check("abort_inputs", {bus.in1, bus.in2, bus.in3}, 0);
                check("abort_pass", bus.pass, 0);
            end
        end
        bus.abort = 1'b0;
        check("abort_no_done", done_cnt, 0);
        check("abort_tt_partial", bus.tt_obs, 8'hB0);
        check("abort_idle_busy", bus.busy, 0);

        sweep("start_beats_abort", 8'hBC, -1, 1'b0, 1'b1);

        for (int i = 0; i < 6; i++) begin
            rtt = ($urandom_range(0, 1) == 1) ? EXP : 8'($urandom);
            ge  = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, SWEEP)) : -1;
            sweep($sformatf("rand%0d", i), rtt, ge, 1'b0, 1'b0);
        end

        // Asynchronous reset while sampling combo 001.
        model_tt = 8'hBC;
        @(negedge clk);
        bus.start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        repeat (PER + S + 1) @(posedge clk);
        #2;
        check("pre_reset_busy", bus.busy, 1);
        rst_n = 1'b0;
        #1;
        check("async_reset_outputs", {bus.busy, bus.done, bus.in1, bus.in2, bus.in3,
                                      bus.unstable, bus.pass, bus.tt_obs}, 0);
        @(negedge clk);
        rst_n    = 1'b1;
        idle_err = 0;
        for (int n = 0; n < 10; n++) begin
            @(negedge clk);
            if ({bus.busy, bus.done, bus.in1, bus.in2, bus.in3} != 0) idle_err++;
        end
        check("post_reset_idle", idle_err, 0);

        sweep("after_reset", 8'hBC, -1, 1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
